// File: rtl/qdma_app_pkg.sv
// Shared types and defaults for the QDMA application-layer step sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//   seq_state_t     : sequencer FSM states
//   STEP_W_DEF      : default width of the step-count field in h2c tuser_mdata
//   MAX_STEPS_DEF   : default clamp on DUT cycles per packet
//   MDATA_STEP_OFS  : bit offset of the step-count field inside tuser_mdata
package qdma_app_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    SETTLE,
    CAPTURE,
    WAIT_C2H
  } seq_state_t;

  localparam int STEP_W_DEF     = 16;
  localparam int MAX_STEPS_DEF  = 1024;
  localparam int MDATA_W        = 32;
  localparam int MDATA_STEP_OFS = 0;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with a zero flag; stops at zero instead of wrapping.
// Latency: load/decrement visible the cycle after i_load/i_dec.
// Backpressure: none; load takes priority over decrement.
//   clk, rst_n  : clock, async active-low reset (count clears to 0)
//   i_load      : load i_load_val this cycle
//   i_load_val  : value to load
//   i_dec       : decrement by one unless already zero
//   o_zero      : current count is zero
module seq_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/dut_step_sequencer.sv
// Per H2C packet: gate the DUT clock for N cycles, settle, pulse C2H capture, wait for C2H.
// Latency: CE rises the cycle after h2c_pkt_done; capture follows the last CE cycle by SETTLE_CYCLES+1.
// Backpressure: ctrl_h2c_en is low outside IDLE; WAIT_C2H ends on c2h_pkt_sent or timeout.
//   Inputs : clk, rst_n, h2c_pkt_done, h2c_pkt_mdata[31:0], c2h_pkt_sent
//   Outputs: ctrl_h2c_en, dut_clk_en, ctrl_c2h_capture, busy, steps_done, err_clamp, err_timeout
//   Optional (macro DUT_STEP_STATS_EN): stat_pkts[31:0], stat_cycles[47:0]
module dut_step_sequencer
  import qdma_app_pkg::*;
#(
  parameter int STEP_W        = STEP_W_DEF,
  parameter int MAX_STEPS     = MAX_STEPS_DEF,
  parameter int SETTLE_CYCLES = 1,
  parameter int C2H_TIMEOUT   = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               h2c_pkt_done,
  input  logic [MDATA_W-1:0] h2c_pkt_mdata,
  input  logic               c2h_pkt_sent,
  output logic               ctrl_h2c_en,
  output logic               dut_clk_en,
  output logic               ctrl_c2h_capture,
  output logic               busy,
  output logic [STEP_W-1:0]  steps_done,
  output logic               err_clamp,
`ifdef DUT_STEP_STATS_EN
  output logic [31:0]        stat_pkts,
  output logic [47:0]        stat_cycles,
`endif
  output logic               err_timeout
);

  // steps_done can never saturate in practice because the clamp is below its range.
  if (longint'(MAX_STEPS) >= (64'(1) << STEP_W) || MAX_STEPS < 1) begin : g_bad_max_steps
    $error("dut_step_sequencer: MAX_STEPS must be in 1 .. 2**STEP_W-1");
  end

  // One counter serves both RUN and SETTLE, so size it for the larger of the two.
  localparam int CNT_MAX   = (MAX_STEPS > SETTLE_CYCLES) ? MAX_STEPS : SETTLE_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int TO_W      = (C2H_TIMEOUT > 1) ? $clog2(C2H_TIMEOUT + 1) : 1;
  localparam bit SETTLE_EN = (SETTLE_CYCLES > 0);
  localparam bit TO_EN     = (C2H_TIMEOUT > 0);
  // Counters are loaded with length-1 so the zero flag marks the final cycle of a phase.
  localparam logic [CNT_W-1:0] SETTLE_LD = SETTLE_EN ? CNT_W'(SETTLE_CYCLES - 1) : '0;
  localparam logic [TO_W-1:0]  TO_LD     = TO_EN ? TO_W'(C2H_TIMEOUT - 1) : '0;

  seq_state_t        r_state;
  logic              r_h2c_en;
  logic              r_clk_en;
  logic              r_capture;
  logic [STEP_W-1:0] r_steps;
  logic              r_err_clamp;
  logic              r_err_timeout;

  logic [STEP_W-1:0] w_req;
  logic              w_clamp;
  logic [STEP_W-1:0] w_n_eff;
  logic              w_step_load;
  logic [CNT_W-1:0]  w_step_val;
  logic              w_step_dec;
  logic              w_step_zero;
  logic              w_to_load;
  logic              w_to_dec;
  logic              w_to_zero;
  logic              w_unused_mdata;

  assign w_req          = h2c_pkt_mdata[MDATA_STEP_OFS +: STEP_W];
  assign w_clamp        = (w_req > STEP_W'(MAX_STEPS));
  assign w_n_eff        = (w_req == '0) ? STEP_W'(1) : (w_clamp ? STEP_W'(MAX_STEPS) : w_req);
  assign w_unused_mdata = ^h2c_pkt_mdata;

  always_comb begin
    w_step_load = 1'b0;
    w_step_val  = '0;
    w_step_dec  = 1'b0;
    w_to_load   = 1'b0;
    w_to_dec    = 1'b0;
    case (r_state)
      IDLE: begin
        if (h2c_pkt_done) begin
          w_step_load = 1'b1;
          w_step_val  = CNT_W'(w_n_eff - STEP_W'(1));
        end
      end
      RUN: begin
        if (w_step_zero) begin
          w_step_load = SETTLE_EN;
          w_step_val  = SETTLE_LD;
        end else begin
          w_step_dec = 1'b1;
        end
      end
      SETTLE:   w_step_dec = 1'b1;
      CAPTURE:  w_to_load  = 1'b1;
      WAIT_C2H: w_to_dec   = 1'b1;
      default: ;
    endcase
  end

  seq_down_counter #(.W(CNT_W)) u_step_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_step_load),
    .i_load_val (w_step_val),
    .i_dec      (w_step_dec),
    .o_zero     (w_step_zero)
  );

  seq_down_counter #(.W(TO_W)) u_to_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_to_load),
    .i_load_val (TO_LD),
    .i_dec      (w_to_dec),
    .o_zero     (w_to_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_h2c_en      <= 1'b1;
      r_clk_en      <= 1'b0;
      r_capture     <= 1'b0;
      r_steps       <= '0;
      r_err_clamp   <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (h2c_pkt_done) begin
            r_state  <= RUN;
            r_h2c_en <= 1'b0;
            r_clk_en <= 1'b1;
            r_steps  <= '0;
            if (w_clamp) r_err_clamp <= 1'b1;
          end
        end
        RUN: begin
          if (r_steps != '1) r_steps <= r_steps + STEP_W'(1);
          if (w_step_zero) begin
            r_clk_en <= 1'b0;
            if (SETTLE_EN) begin
              r_state <= SETTLE;
            end else begin
              r_state   <= CAPTURE;
              r_capture <= 1'b1;
            end
          end
        end
        SETTLE: begin
          if (w_step_zero) begin
            r_state   <= CAPTURE;
            r_capture <= 1'b1;
          end
        end
        CAPTURE: begin
          r_capture <= 1'b0;
          r_state   <= WAIT_C2H;
        end
        WAIT_C2H: begin
          // A sent pulse on the final timeout cycle takes priority over the abort.
          if (c2h_pkt_sent) begin
            r_state  <= IDLE;
            r_h2c_en <= 1'b1;
          end else if (TO_EN && w_to_zero) begin
            r_err_timeout <= 1'b1;
            r_state       <= IDLE;
            r_h2c_en      <= 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_h2c_en  <= 1'b1;
          r_clk_en  <= 1'b0;
          r_capture <= 1'b0;
        end
      endcase
    end
  end

  assign ctrl_h2c_en      = r_h2c_en;
  assign dut_clk_en       = r_clk_en;
  assign ctrl_c2h_capture = r_capture;
  assign busy             = (r_state != IDLE);
  assign steps_done       = r_steps;
  assign err_clamp        = r_err_clamp;
  assign err_timeout      = r_err_timeout;

`ifdef DUT_STEP_STATS_EN
  logic [31:0] r_stat_pkts;
  logic [47:0] r_stat_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_pkts   <= '0;
      r_stat_cycles <= '0;
    end else begin
      if (r_clk_en) r_stat_cycles <= r_stat_cycles + 48'd1;
      if ((r_state == WAIT_C2H) && c2h_pkt_sent) r_stat_pkts <= r_stat_pkts + 32'd1;
    end
  end

  assign stat_pkts   = r_stat_pkts;
  assign stat_cycles = r_stat_cycles;
`endif

endmodule

// File: tb/tb_dut_step_sequencer.sv
// Bench for dut_step_sequencer: instance A (SETTLE=1, timeout 16), instance B (SETTLE=0, no timeout).
// Expected CE/capture cycles are queued when a packet is driven and popped as the DUT produces them.
// Stats outputs are checked when DUT_STEP_STATS_EN is defined.
module tb_dut_step_sequencer;

  localparam int STEP_W   = 16;
  localparam int MAXS     = 1024;
  localparam int A_SETTLE = 1;
  localparam int A_TO     = 16;
  localparam int B_SETTLE = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic a_done, a_sent, b_done, b_sent;
  logic [31:0] a_mdata, b_mdata;
  logic a_h2c_en, a_ce, a_cap, a_busy, a_err_clamp, a_err_to;
  logic b_h2c_en, b_ce, b_cap, b_busy, b_err_clamp, b_err_to;
  logic [STEP_W-1:0] a_steps, b_steps;
`ifdef DUT_STEP_STATS_EN
  logic [31:0] a_stat_pkts, b_stat_pkts;
  logic [47:0] a_stat_cycles, b_stat_cycles;
`endif

  dut_step_sequencer #(.STEP_W(STEP_W), .MAX_STEPS(MAXS), .SETTLE_CYCLES(A_SETTLE), .C2H_TIMEOUT(A_TO)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .h2c_pkt_done(a_done), .h2c_pkt_mdata(a_mdata), .c2h_pkt_sent(a_sent),
    .ctrl_h2c_en(a_h2c_en), .dut_clk_en(a_ce), .ctrl_c2h_capture(a_cap), .busy(a_busy),
    .steps_done(a_steps), .err_clamp(a_err_clamp),
`ifdef DUT_STEP_STATS_EN
    .stat_pkts(a_stat_pkts), .stat_cycles(a_stat_cycles),
`endif
    .err_timeout(a_err_to)
  );

  dut_step_sequencer #(.STEP_W(STEP_W), .MAX_STEPS(MAXS), .SETTLE_CYCLES(B_SETTLE), .C2H_TIMEOUT(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .h2c_pkt_done(b_done), .h2c_pkt_mdata(b_mdata), .c2h_pkt_sent(b_sent),
    .ctrl_h2c_en(b_h2c_en), .dut_clk_en(b_ce), .ctrl_c2h_capture(b_cap), .busy(b_busy),
    .steps_done(b_steps), .err_clamp(b_err_clamp),
`ifdef DUT_STEP_STATS_EN
    .stat_pkts(b_stat_pkts), .stat_cycles(b_stat_cycles),
`endif
    .err_timeout(b_err_to)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int a_ce_q[$], a_cap_q[$], b_ce_q[$], b_cap_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard side: every observed CE/capture cycle must match the next queued expectation.
  always @(negedge clk) begin
    while (a_ce_q.size() > 0 && a_ce_q[0] < cyc) chk("a_ce_missed", a_ce_q.pop_front(), cyc);
    while (a_cap_q.size() > 0 && a_cap_q[0] < cyc) chk("a_cap_missed", a_cap_q.pop_front(), cyc);
    while (b_ce_q.size() > 0 && b_ce_q[0] < cyc) chk("b_ce_missed", b_ce_q.pop_front(), cyc);
    while (b_cap_q.size() > 0 && b_cap_q[0] < cyc) chk("b_cap_missed", b_cap_q.pop_front(), cyc);
    if (a_ce !== 1'b0) begin
      if (a_ce_q.size() == 0) chk("a_ce_unexpected", a_ce, 0);
      else chk("a_ce_cycle", cyc, a_ce_q.pop_front());
    end
    if (a_cap !== 1'b0) begin
      if (a_cap_q.size() == 0) chk("a_cap_unexpected", a_cap, 0);
      else chk("a_cap_cycle", cyc, a_cap_q.pop_front());
    end
    if (b_ce !== 1'b0) begin
      if (b_ce_q.size() == 0) chk("b_ce_unexpected", b_ce, 0);
      else chk("b_ce_cycle", cyc, b_ce_q.pop_front());
    end
    if (b_cap !== 1'b0) begin
      if (b_cap_q.size() == 0) chk("b_cap_unexpected", b_cap, 0);
      else chk("b_cap_cycle", cyc, b_cap_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  // Drive one h2c_pkt_done on instance A (sel=0) or B (sel=1) and queue the expected timeline.
  task automatic send(input bit sel, input logic [31:0] md, output int t);
    int n;
    n = int'(md[15:0]);
    if (n == 0) n = 1;
    if (n > MAXS) n = MAXS;
    step();
    t = cyc;
    if (sel == 1'b0) begin
      a_done = 1'b1; a_mdata = md;
      for (int k = 1; k <= n; k++) a_ce_q.push_back(t + k);
      a_cap_q.push_back(t + n + 1 + A_SETTLE);
    end else begin
      b_done = 1'b1; b_mdata = md;
      for (int k = 1; k <= n; k++) b_ce_q.push_back(t + k);
      b_cap_q.push_back(t + n + 1 + B_SETTLE);
    end
    step();
    a_done = 1'b0; b_done = 1'b0;
    a_mdata = $urandom; b_mdata = $urandom;
  endtask

  task automatic pulse_sent(input bit sel, input int c);
    wait_to(c);
    if (sel == 1'b0) a_sent = 1'b1; else b_sent = 1'b1;
    step();
    a_sent = 1'b0; b_sent = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d required < 100000", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    rst_n = 1'b0;
    a_done = 1'b0; a_sent = 1'b0; a_mdata = '0;
    b_done = 1'b0; b_sent = 1'b0; b_mdata = '0;
    step(); step(); step();
    chk("rst_h2c_en", a_h2c_en, 1);
    chk("rst_ce", a_ce, 0);
    chk("rst_cap", a_cap, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_steps", a_steps, 0);
    chk("rst_err_clamp", a_err_clamp, 0);
    chk("rst_err_to", a_err_to, 0);
    rst_n = 1'b1;
    step();

    // Step field 0 (upper mdata bits ignored) -> one CE cycle, capture at t+3, sent at t+10.
    send(1'b0, 32'hABCD_0000, t);
    wait_to(t + 10);
    chk("t1_h2c_en_wait", a_h2c_en, 0);
    chk("t1_busy_wait", a_busy, 1);
    chk("t1_steps", a_steps, 1);
    pulse_sent(1'b0, t + 10);
    chk("t1_h2c_en_after", a_h2c_en, 1);
    chk("t1_busy_after", a_busy, 0);
    chk("t1_err_clamp", a_err_clamp, 0);

    // Instance B, no settle: CE t+1..t+5, capture t+6; no timeout while waiting.
    send(1'b1, 32'd5, t);
    wait_to(t + 7);
    chk("b_steps", b_steps, 5);
    wait_to(t + 60);
    chk("b_busy_no_to", b_busy, 1);
    chk("b_err_to", b_err_to, 0);
    chk("b_h2c_en_wait", b_h2c_en, 0);
    pulse_sent(1'b1, t + 60);
    chk("b_h2c_en_after", b_h2c_en, 1);

    // Clamp: 5000 -> 1024 CE cycles; a stray sent pulse during RUN is ignored.
    send(1'b0, 32'd5000, t);
    pulse_sent(1'b0, t + 10);
    chk("clamp_busy_run", a_busy, 1);
    chk("clamp_err_early", a_err_clamp, 1);
    pulse_sent(1'b0, t + 1030);
    chk("clamp_steps", a_steps, 1024);
    chk("clamp_err", a_err_clamp, 1);
    chk("clamp_h2c_en", a_h2c_en, 1);

    // Sent on the final WAIT_C2H cycle wins over the timeout.
    send(1'b0, 32'd2, t);
    wait_to(t + 20);
    chk("sot_busy", a_busy, 1);
    pulse_sent(1'b0, t + 20);
    chk("sot_idle", a_busy, 0);
    chk("sot_err_to", a_err_to, 0);
    chk("sot_err_clamp_sticky", a_err_clamp, 1);

    // Timeout: WAIT_C2H entered at t+6, IDLE 16 cycles later at t+22.
    send(1'b0, 32'd3, t);
    wait_to(t + 21);
    chk("to_busy_last", a_busy, 1);
    chk("to_err_before", a_err_to, 0);
    wait_to(t + 22);
    chk("to_idle", a_busy, 0);
    chk("to_err", a_err_to, 1);
    chk("to_h2c_en", a_h2c_en, 1);
`ifdef DUT_STEP_STATS_EN
    chk("stat_pkts_pre", a_stat_pkts, 3);
    chk("stat_cycles_pre", a_stat_cycles, 1030);
`endif

    // Reset during RUN on step 3 of 8: CE drops at once and no capture follows.
    send(1'b0, 32'd8, t);
    wait_to(t + 3);
    chk("mr_steps", a_steps, 2);
    chk("mr_ce_before", a_ce, 1);
    chk("mr_err_to_sticky", a_err_to, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_ce_now", a_ce, 0);
    chk("mr_busy_now", a_busy, 0);
    a_ce_q.delete();
    a_cap_q.delete();
    step(); step(); step();
    rst_n = 1'b1;
    step();
    wait_to(cyc + 20);
    chk("mr_h2c_en", a_h2c_en, 1);
    chk("mr_err_clamp", a_err_clamp, 0);
    chk("mr_err_to", a_err_to, 0);
    chk("mr_steps_clr", a_steps, 0);

    // Three packets of 2, 3, 4 steps, each acknowledged one cycle into WAIT_C2H.
    for (int i = 2; i <= 4; i++) begin
      send(1'b0, 32'(i), t);
      pulse_sent(1'b0, t + i + 4);
      chk("pkt_idle", a_busy, 0);
    end
    chk("pkt_steps_last", a_steps, 4);
`ifdef DUT_STEP_STATS_EN
    chk("stat_pkts", a_stat_pkts, 3);
    chk("stat_cycles", a_stat_cycles, 9);
    chk("b_stat_pkts", b_stat_pkts, 1);
    chk("b_stat_cycles", b_stat_cycles, 5);
`endif

    step(); step();
    chk("a_ce_q_empty", a_ce_q.size(), 0);
    chk("a_cap_q_empty", a_cap_q.size(), 0);
    chk("b_ce_q_empty", b_ce_q.size(), 0);
    chk("b_cap_q_empty", b_cap_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
